// File: rtl/sensor_frame_pkg.sv
// Shared types and helpers for the sensor frame receiver.
// Contents:
//   rx_state_t      - receiver FSM state encoding
//   FRAME_DATA_BITS - payload width of one frame
//   FRAME_CRC_BITS  - CRC width of one frame
//   crc8_step       - one bit-serial CRC-8 update (MSB-first, x^8 implicit)
package sensor_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2,
        STOP = 2'd3
    } rx_state_t;

    localparam int FRAME_DATA_BITS = 8;
    localparam int FRAME_CRC_BITS  = 8;

    // Feedback is the outgoing MSB xor the incoming bit; it selects the polynomial.
    function automatic logic [7:0] crc8_step(
        input logic [7:0] crc,
        input logic       bit_in,
        input logic [7:0] poly
    );
        logic fb_s;
        fb_s = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb_s ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 LFSR.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset, loads INIT
//   init   - reload register with INIT (takes priority over en)
//   en     - advance the LFSR by one bit
//   bit_in - serial bit fed into the CRC
//   crc    - current CRC register value
module crc8_serial
    import sensor_frame_pkg::*;
#(
    parameter logic [7:0] POLY = 8'h07,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    // CRC register: reload on reset/init, otherwise step on each enabled bit
    always_ff @(posedge clk) begin
        if (reset) begin
            crc <= INIT;
        end else if (init) begin
            crc <= INIT;
        end else if (en) begin
            crc <= crc8_step(crc, bit_in, POLY);
        end else begin
            crc <= crc;
        end
    end

endmodule

// File: rtl/sensor_frame_rx.sv
// Serial sensor frame receiver: start bit, 8 data bits, 8 CRC bits, stop bit,
// all MSB first, sampled on bit_valid. CRC-8 is computed over the data bits
// while they arrive and presented to the downstream checker with the frame.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   serial_in    - line data, idles high
//   bit_valid    - sample strobe for serial_in
//   dado_out     - data byte of the last good frame
//   crc_out      - received CRC byte of the last good frame
//   crc_calc     - locally computed CRC over dado_out
//   frame_valid  - one-cycle pulse when the three bytes above update
//   crc_ok       - crc_calc == crc_out, updated with frame_valid
//   frame_err    - one-cycle pulse on bad stop bit or inter-bit timeout
//   busy         - high whenever a frame is in progress
module sensor_frame_rx
    import sensor_frame_pkg::*;
#(
    parameter logic [7:0] POLY    = 8'h07,
    parameter logic [7:0] INIT    = 8'h00,
    parameter int         TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    input  logic       bit_valid,
    output logic [7:0] dado_out,
    output logic [7:0] crc_out,
    output logic [7:0] crc_calc,
    output logic       frame_valid,
    output logic       crc_ok,
    output logic       frame_err,
    output logic       busy
);

    localparam int              TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT);
    localparam logic [2:0]      DATA_LAST = 3'(FRAME_DATA_BITS - 1);
    localparam logic [2:0]      CRC_LAST  = 3'(FRAME_CRC_BITS - 1);

    rx_state_t       state_r, state_next_s;
    logic [2:0]      bit_cnt_r, bit_cnt_next_s;
    logic [TO_W-1:0] to_cnt_r, to_cnt_next_s;
    logic [7:0]      data_sr_r;
    logic [7:0]      crcrx_sr_r;
    logic [7:0]      crc_run_s;
    logic            crc_init_s;
    logic            crc_en_s;
    logic            data_shift_s;
    logic            crcrx_shift_s;
    logic            good_s;
    logic            bad_s;
    logic            timeout_s;

    crc8_serial #(
        .POLY (POLY),
        .INIT (INIT)
    ) u_crc (
        .clk    (clk),
        .reset  (reset),
        .init   (crc_init_s),
        .en     (crc_en_s),
        .bit_in (serial_in),
        .crc    (crc_run_s)
    );

    // Stall detection: the counter has seen TIMEOUT strobe-less cycles inside a frame
    always_comb begin
        timeout_s = 1'b0;
        if ((state_r != IDLE) && (to_cnt_r == TO_LIMIT)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Next-state and datapath control; a timeout wins over a coincident strobe
    always_comb begin
        state_next_s   = state_r;
        bit_cnt_next_s = bit_cnt_r;
        crc_init_s     = 1'b0;
        crc_en_s       = 1'b0;
        data_shift_s   = 1'b0;
        crcrx_shift_s  = 1'b0;
        good_s         = 1'b0;
        bad_s          = 1'b0;
        if ((state_r == IDLE) || bit_valid || timeout_s) begin
            to_cnt_next_s = '0;
        end else begin
            to_cnt_next_s = to_cnt_r + TO_W'(1);
        end
        case (state_r)
            IDLE: begin
                if (bit_valid && !serial_in) begin
                    state_next_s   = DATA;
                    crc_init_s     = 1'b1;
                    bit_cnt_next_s = 3'd0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DATA: begin
                if (timeout_s) begin
                    bad_s        = 1'b1;
                    state_next_s = IDLE;
                end else if (bit_valid) begin
                    data_shift_s   = 1'b1;
                    crc_en_s       = 1'b1;
                    bit_cnt_next_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == DATA_LAST) begin
                        state_next_s = CRC;
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            CRC: begin
                if (timeout_s) begin
                    bad_s        = 1'b1;
                    state_next_s = IDLE;
                end else if (bit_valid) begin
                    crcrx_shift_s  = 1'b1;
                    bit_cnt_next_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == CRC_LAST) begin
                        state_next_s = STOP;
                    end else begin
                        state_next_s = CRC;
                    end
                end else begin
                    state_next_s = CRC;
                end
            end
            STOP: begin
                if (timeout_s) begin
                    bad_s        = 1'b1;
                    state_next_s = IDLE;
                end else if (bit_valid) begin
                    // A low stop bit is a framing error, never a new start bit
                    if (serial_in) begin
                        good_s = 1'b1;
                    end else begin
                        bad_s = 1'b1;
                    end
                    state_next_s = IDLE;
                end else begin
                    state_next_s = STOP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Control state, counters and shift registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            bit_cnt_r  <= 3'd0;
            to_cnt_r   <= '0;
            data_sr_r  <= 8'h00;
            crcrx_sr_r <= 8'h00;
        end else begin
            state_r   <= state_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            to_cnt_r  <= to_cnt_next_s;
            if (data_shift_s) begin
                data_sr_r <= {data_sr_r[6:0], serial_in};
            end else begin
                data_sr_r <= data_sr_r;
            end
            if (crcrx_shift_s) begin
                crcrx_sr_r <= {crcrx_sr_r[6:0], serial_in};
            end else begin
                crcrx_sr_r <= crcrx_sr_r;
            end
        end
    end

    // Registered outputs; frame bytes only change on a good stop bit
    always_ff @(posedge clk) begin
        if (reset) begin
            dado_out    <= 8'h00;
            crc_out     <= 8'h00;
            crc_calc    <= INIT;
            crc_ok      <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_valid <= good_s;
            frame_err   <= bad_s;
            busy        <= (state_next_s != IDLE);
            if (good_s) begin
                dado_out <= data_sr_r;
                crc_out  <= crcrx_sr_r;
                crc_calc <= crc_run_s;
                crc_ok   <= (crc_run_s == crcrx_sr_r);
            end else begin
                dado_out <= dado_out;
                crc_out  <= crc_out;
                crc_calc <= crc_calc;
                crc_ok   <= crc_ok;
            end
        end
    end

endmodule

// File: tb/tb_sensor_frame_rx.sv
// Scoreboard bench for sensor_frame_rx: the stimulus process queues the
// expected result of every frame it sends; the monitor pops and compares
// whenever frame_valid or frame_err is seen.
module tb_sensor_frame_rx;

    localparam int TIMEOUT = 64;

    logic       clk;
    logic       reset;
    logic       serial_in;
    logic       bit_valid;
    logic [7:0] dado_out;
    logic [7:0] crc_out;
    logic [7:0] crc_calc;
    logic       frame_valid;
    logic       crc_ok;
    logic       frame_err;
    logic       busy;

    typedef struct {
        logic       is_err;
        logic [7:0] d;
        logic [7:0] c;
        logic [7:0] k;
        logic       ok;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks;
    int   errors;

    // expected held output values (last good frame)
    logic [7:0] last_d, last_c, last_k;
    logic       last_ok;

    sensor_frame_rx #(
        .POLY    (8'h07),
        .INIT    (8'h00),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .serial_in   (serial_in),
        .bit_valid   (bit_valid),
        .dado_out    (dado_out),
        .crc_out     (crc_out),
        .crc_calc    (crc_calc),
        .frame_valid (frame_valid),
        .crc_ok      (crc_ok),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle with a pulse consumes one scoreboard entry
    always @(negedge clk) begin
        if (!reset && (frame_valid || frame_err)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: frame_valid=%0b frame_err=%0b with empty scoreboard at %0t",
                         frame_valid, frame_err, $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("pulse_exclusive", {7'd0, frame_valid & frame_err}, 8'h00);
                chk("pulse_is_err", {7'd0, frame_err}, {7'd0, mon_e.is_err});
                chk("dado_out", dado_out, mon_e.d);
                chk("crc_out", crc_out, mon_e.c);
                chk("crc_calc", crc_calc, mon_e.k);
                chk("crc_ok", {7'd0, crc_ok}, {7'd0, mon_e.ok});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
        serial_in = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
        end
    endtask

    // Queue the expectation, then drive the whole frame with no gaps
    task automatic send_frame(input logic [7:0] d, input logic [7:0] c,
                              input logic [7:0] k, input logic stop);
        exp_t e;
        if (stop) begin
            last_d  = d;
            last_c  = c;
            last_k  = k;
            last_ok = (k == c);
            e.is_err = 1'b0;
        end else begin
            e.is_err = 1'b1;
        end
        e.d  = last_d;
        e.c  = last_c;
        e.k  = last_k;
        e.ok = last_ok;
        sb_q.push_back(e);
        send_bit(1'b0);
        send_byte(d);
        send_byte(c);
        send_bit(stop);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_dado"}, dado_out, 8'h00);
        chk({tag, "_crc_out"}, crc_out, 8'h00);
        chk({tag, "_crc_calc"}, crc_calc, 8'h00);
        chk({tag, "_crc_ok"}, {7'd0, crc_ok}, 8'h00);
        chk({tag, "_frame_valid"}, {7'd0, frame_valid}, 8'h00);
        chk({tag, "_frame_err"}, {7'd0, frame_err}, 8'h00);
        chk({tag, "_busy"}, {7'd0, busy}, 8'h00);
    endtask

    initial begin
        exp_t e;
        checks    = 0;
        errors    = 0;
        last_d    = 8'h00;
        last_c    = 8'h00;
        last_k    = 8'h00;
        last_ok   = 1'b0;
        reset     = 1'b1;
        serial_in = 1'b1;
        bit_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check_reset_state("init");
        tick();

        // good frames, hand-computed CRC-8 (poly 07, init 00)
        send_frame(8'h00, 8'h00, 8'h00, 1'b1);
        tick();
        send_frame(8'hFF, 8'hF3, 8'hF3, 1'b1);
        send_frame(8'h80, 8'h89, 8'h89, 1'b1);
        // corrupted received CRC
        send_frame(8'h00, 8'h37, 8'h00, 1'b1);
        send_frame(8'h00, 8'h38, 8'h00, 1'b1);
        send_frame(8'h01, 8'h07, 8'h07, 1'b1);
        // bad stop bit: error pulse, outputs hold the 01/07 frame
        send_frame(8'h01, 8'h07, 8'h07, 1'b0);
        repeat (2) tick();
        chk("held_dado", dado_out, 8'h01);
        chk("held_crc_out", crc_out, 8'h07);
        chk("held_crc_ok", {7'd0, crc_ok}, 8'h01);
        chk("idle_after_bad_stop", {7'd0, busy}, 8'h00);

        // stall after 5 data bits -> one timeout error
        e.is_err = 1'b1;
        e.d = last_d; e.c = last_c; e.k = last_k; e.ok = last_ok;
        sb_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        chk("busy_mid_frame", {7'd0, busy}, 8'h01);
        repeat (TIMEOUT + 5) tick();
        chk("busy_after_timeout", {7'd0, busy}, 8'h00);
        chk("sb_drained_timeout", 8'(sb_q.size()), 8'h00);
        send_frame(8'hFF, 8'hF3, 8'hF3, 1'b1);
        tick();

        // reset during CRC phase, strobe with a start-like bit held during reset
        send_bit(1'b0);
        send_byte(8'h01);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        reset     = 1'b1;
        bit_valid = 1'b1;
        serial_in = 1'b0;
        tick();
        reset     = 1'b0;
        bit_valid = 1'b0;
        serial_in = 1'b1;
        check_reset_state("midreset");
        last_d = 8'h00; last_c = 8'h00; last_k = 8'h00; last_ok = 1'b0;

        // back-to-back frames with no idle bits between them
        send_frame(8'h01, 8'h07, 8'h07, 1'b1);
        send_frame(8'h80, 8'h89, 8'h89, 1'b1);
        repeat (4) tick();
        chk("final_dado", dado_out, 8'h80);
        chk("final_crc_ok", {7'd0, crc_ok}, 8'h01);
        chk("sb_drained_final", 8'(sb_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL time_limit: simulation exceeded 200000 time units");
        $fatal(1, "time limit");
    end

endmodule
